// File: rtl/fp_mult_serial_if.sv
// Byte-serial bus between a host and the fp_mult_serial multiplier.
// The host (master) drives operand bytes; the multiplier (slave) returns result bytes.
interface fp_mult_serial_if;
  logic [7:0] DATA_IN;
  logic       ENABLE;
  logic [7:0] DATA_OUT;
  logic       READY;

  modport master (output DATA_IN, ENABLE, input DATA_OUT, READY);
  modport slave  (input DATA_IN, ENABLE, output DATA_OUT, READY);
endinterface

// File: rtl/fp_mult_serial.sv
// Byte-serial IEEE-754 binary64 multiplier (RNE, full special-case handling).
// Define FP_MULT_FTZ_EN to flush subnormal inputs and sub-min-normal results to signed zero.
module fp_mult_serial (
  input  logic             CLK,
  input  logic             RESET,
  fp_mult_serial_if.slave  bus
);

`ifdef FP_MULT_FTZ_EN
  localparam bit FTZ_EN = 1'b1;
`else
  localparam bit FTZ_EN = 1'b0;
`endif

  typedef enum logic [1:0] {S_LOAD, S_CALC, S_OUT} state_t;

  typedef struct packed {
    logic [52:0] m;
    logic [13:0] e;
    logic        zero;
    logic        inf;
    logic        nan;
  } operand_t;

  // Left shift that brings the top set bit of a subnormal fraction up to the implicit-bit position.
  function automatic logic [5:0] lead_shift(input logic [51:0] f);
    logic [5:0] s;
    s = 6'd0;
    for (int i = 0; i < 52; i++) begin
      if (f[i]) s = 6'(52 - i);
    end
    return s;
  endfunction

  function automatic operand_t unpack(input logic [63:0] v);
    operand_t   o;
    logic [5:0] sh;
    sh     = lead_shift(v[51:0]);
    o.m    = {1'b1, v[51:0]};
    o.e    = {3'b000, v[62:52]};
    o.nan  = (&v[62:52]) & (|v[51:0]);
    o.inf  = (&v[62:52]) & ~(|v[51:0]);
    o.zero = (v[62:52] == 11'd0) & (FTZ_EN | (v[51:0] == 52'd0));
    if (v[62:52] == 11'd0) begin
      o.m = {1'b0, v[51:0]} << sh;
      o.e = 14'd1 - {8'd0, sh};
    end
    return o;
  endfunction

  state_t              state;
  logic [3:0]          byte_cnt;
  logic [1:0]          calc_cnt;
  logic [3:0]          out_cnt;
  logic [127:0]        op_reg;
  logic [63:0]         res_sh;
  logic [7:0]          data_out_q;
  logic                ready_q;

  logic                s1_special, s2_special;
  logic [63:0]         s1_special_val, s2_special_val;
  logic                s1_sign, s2_sign;
  logic signed [13:0]  s1_exp, s2_exp;
  logic [105:0]        s1_prod, s2_mant;
  logic                s2_sticky, s2_denorm;

  operand_t            ux, uy;
  logic                s1c_special, s1c_sign;
  logic [63:0]         s1c_special_val;
  logic signed [13:0]  s1c_exp;
  logic [105:0]        s1c_prod;

  logic [105:0]        norm_m, s2c_m;
  logic signed [13:0]  norm_e;
  logic [13:0]         rshift;
  logic                s2c_sticky, s2c_denorm;

  logic [52:0]         kept;
  logic                guard_b, round_b, sticky_b, round_up;
  logic [53:0]         sum;
  logic signed [13:0]  exp_f;
  logic [63:0]         s3c_result;

  assign bus.DATA_OUT = data_out_q;
  assign bus.READY    = ready_q;

  // Unpack, special-case detection and the full 53x53 significand product.
  always_comb begin
    ux              = unpack(op_reg[127:64]);
    uy              = unpack(op_reg[63:0]);
    s1c_sign        = op_reg[127] ^ op_reg[63];
    s1c_prod        = 106'(ux.m) * 106'(uy.m);
    s1c_exp         = ux.e + uy.e - 14'd1023;
    s1c_special     = 1'b1;
    s1c_special_val = 64'd0;
    if (ux.nan)
      s1c_special_val = {op_reg[127:116], 1'b1, op_reg[114:64]};
    else if (uy.nan)
      s1c_special_val = {op_reg[63:52], 1'b1, op_reg[50:0]};
    else if ((ux.inf & uy.zero) | (ux.zero & uy.inf))
      s1c_special_val = 64'hFFF8_0000_0000_0000;
    else if (ux.inf | uy.inf)
      s1c_special_val = {s1c_sign, 11'h7FF, 52'd0};
    else if (ux.zero | uy.zero)
      s1c_special_val = {s1c_sign, 63'd0};
    else
      s1c_special = 1'b0;
  end

  // Normalize so the leading one sits at bit 105; tiny results are shifted into subnormal range.
  always_comb begin
    norm_m     = s1_prod[105] ? s1_prod : (s1_prod << 1);
    norm_e     = s1_prod[105] ? (s1_exp + 14'sd1) : s1_exp;
    rshift     = 14'd1 - norm_e;
    s2c_m      = norm_m;
    s2c_sticky = 1'b0;
    s2c_denorm = 1'b0;
    if (norm_e <= 14'sd0) begin
      s2c_denorm = 1'b1;
      if (rshift >= 14'd106) begin
        s2c_m      = 106'd0;
        s2c_sticky = |norm_m;
      end else begin
        s2c_m      = norm_m >> rshift;
        s2c_sticky = |(norm_m & ~({106{1'b1}} << rshift));
      end
    end
  end

  always_comb begin
    kept     = s2_mant[105:53];
    guard_b  = s2_mant[52];
    round_b  = s2_mant[51];
    sticky_b = (|s2_mant[50:0]) | s2_sticky;
    round_up = guard_b & (round_b | sticky_b | kept[0]);
    sum      = {1'b0, kept} + 54'(round_up);
    exp_f    = s2_exp + {13'd0, sum[53]};
    if (s2_special)
      s3c_result = s2_special_val;
    else if (s2_denorm) begin
      if (FTZ_EN && !sum[52])
        s3c_result = {s2_sign, 63'd0};
      else
        s3c_result = {s2_sign, 10'd0, sum[52], sum[51:0]};
    end else if (exp_f >= 14'sd2047)
      s3c_result = {s2_sign, 11'h7FF, 52'd0};
    else
      s3c_result = {s2_sign, exp_f[10:0], (sum[53] ? 52'd0 : sum[51:0])};
  end

  // Control FSM plus the three calculation stages, which advance one per CALC cycle.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      state          <= S_LOAD;
      byte_cnt       <= 4'd0;
      calc_cnt       <= 2'd0;
      out_cnt        <= 4'd0;
      op_reg         <= 128'd0;
      res_sh         <= 64'd0;
      data_out_q     <= 8'h00;
      ready_q        <= 1'b0;
      s1_special     <= 1'b0;
      s1_special_val <= 64'd0;
      s1_sign        <= 1'b0;
      s1_exp         <= 14'sd0;
      s1_prod        <= 106'd0;
      s2_special     <= 1'b0;
      s2_special_val <= 64'd0;
      s2_sign        <= 1'b0;
      s2_exp         <= 14'sd0;
      s2_mant        <= 106'd0;
      s2_sticky      <= 1'b0;
      s2_denorm      <= 1'b0;
    end else begin
      case (state)
        S_LOAD: begin
          if (bus.ENABLE) begin
            op_reg   <= {op_reg[119:0], bus.DATA_IN};
            byte_cnt <= byte_cnt + 4'd1;
            if (byte_cnt == 4'd15) begin
              state    <= S_CALC;
              calc_cnt <= 2'd0;
            end
          end
        end
        S_CALC: begin
          calc_cnt <= calc_cnt + 2'd1;
          case (calc_cnt)
            2'd0: begin
              s1_special     <= s1c_special;
              s1_special_val <= s1c_special_val;
              s1_sign        <= s1c_sign;
              s1_exp         <= s1c_exp;
              s1_prod        <= s1c_prod;
            end
            2'd1: begin
              s2_special     <= s1_special;
              s2_special_val <= s1_special_val;
              s2_sign        <= s1_sign;
              s2_exp         <= norm_e;
              s2_mant        <= s2c_m;
              s2_sticky      <= s2c_sticky;
              s2_denorm      <= s2c_denorm;
            end
            default: begin
              res_sh  <= s3c_result;
              out_cnt <= 4'd0;
              state   <= S_OUT;
            end
          endcase
        end
        S_OUT: begin
          if (out_cnt == 4'd8) begin
            ready_q    <= 1'b0;
            data_out_q <= 8'h00;
            byte_cnt   <= 4'd0;
            state      <= S_LOAD;
          end else begin
            ready_q    <= 1'b1;
            data_out_q <= res_sh[63:56];
            res_sh     <= {res_sh[55:0], 8'h00};
            out_cnt    <= out_cnt + 4'd1;
          end
        end
        default: state <= S_LOAD;
      endcase
    end
  end

endmodule

// File: tb/tb_fp_mult_serial.sv
// Self-checking bench for fp_mult_serial: vector table plus gap, reset-abort and back-to-back sequences.
// Expected results are queued when operands are sent and popped when the result bytes arrive.
module tb_fp_mult_serial;

  logic CLK = 1'b0;
  logic RESET;
  always #5 CLK = ~CLK;

  fp_mult_serial_if bus();

  fp_mult_serial dut (
    .CLK   (CLK),
    .RESET (RESET),
    .bus   (bus)
  );

  typedef struct {
    string       name;
    logic [63:0] x;
    logic [63:0] y;
    logic [63:0] r;
  } vec_t;

  vec_t        vecs[16];
  logic [63:0] expQ[$];
  string       nameQ[$];
  int          checks = 0;
  int          passes = 0;

  task automatic checkVal(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
  endtask

  task automatic nextCycle();
    @(posedge CLK);
    @(negedge CLK);
  endtask

  task automatic sendBytes(input logic [127:0] data, input int nbytes, input int gapAfter, input int gapLen);
    for (int i = 0; i < nbytes; i++) begin
      bus.DATA_IN = data[127 - 8*i -: 8];
      bus.ENABLE  = 1'b1;
      nextCycle();
      if (i == gapAfter) begin
        bus.ENABLE  = 1'b0;
        bus.DATA_IN = 8'hEE;
        repeat (gapLen) nextCycle();
      end
    end
    bus.ENABLE  = 1'b0;
    bus.DATA_IN = 8'h00;
  endtask

  // Sends a full operand pair and records the expected result; ENABLE is then held high with junk,
  // which the multiplier must ignore while it calculates and outputs.
  task automatic applyStimulus(input string name, input logic [63:0] x, input logic [63:0] y,
                               input logic [63:0] r, input int gapAfter, input int gapLen);
    sendBytes({x, y}, 16, gapAfter, gapLen);
    expQ.push_back(r);
    nameQ.push_back(name);
    bus.ENABLE  = 1'b1;
    bus.DATA_IN = 8'hA5;
  endtask

  task automatic checkOutput();
    int          lat;
    int          readyCnt;
    logic [63:0] got;
    logic [63:0] exp;
    string       name;
    exp      = expQ.pop_front();
    name     = nameQ.pop_front();
    lat      = 0;
    readyCnt = 0;
    got      = 64'd0;
    while (!bus.READY && lat < 20) begin
      nextCycle();
      lat++;
    end
    if (!bus.READY) begin
      checks++;
      $display("[TB] FAIL %s_timeout: READY never rose, waited %0d cycles, required 4", name, lat);
    end else begin
      checkVal({name, "_latency"}, 64'(lat), 64'd4);
      for (int k = 0; k < 8; k++) begin
        if (bus.READY) readyCnt++;
        got = {got[55:0], bus.DATA_OUT};
        nextCycle();
      end
      checkVal({name, "_result"}, got, exp);
      checkVal({name, "_ready_cycles"}, 64'(readyCnt), 64'd8);
      checkVal({name, "_ready_fall"}, 64'(bus.READY), 64'd0);
      checkVal({name, "_dout_idle"}, 64'(bus.DATA_OUT), 64'd0);
    end
    bus.ENABLE  = 1'b0;
    bus.DATA_IN = 8'h00;
  endtask

  initial begin
    vecs[0]  = '{"mul_1p5x2",      64'h3FF8000000000000, 64'h4000000000000000, 64'h4008000000000000};
    vecs[1]  = '{"neg_one",        64'hBFF0000000000000, 64'h3FF0000000000000, 64'hBFF0000000000000};
    vecs[2]  = '{"inf_x_zero",     64'h7FF0000000000000, 64'h0000000000000000, 64'hFFF8000000000000};
    vecs[3]  = '{"overflow",       64'h7FE0000000000000, 64'h4000000000000000, 64'h7FF0000000000000};
    vecs[4]  = '{"x_nan",          64'h7FF0000000000001, 64'h3FF0000000000000, 64'h7FF8000000000001};
`ifdef FP_MULT_FTZ_EN
    vecs[5]  = '{"tie_even_sub",   64'h0000000000000003, 64'h3FE0000000000000, 64'h0000000000000000};
`else
    vecs[5]  = '{"tie_even_sub",   64'h0000000000000003, 64'h3FE0000000000000, 64'h0000000000000002};
`endif
    vecs[6]  = '{"sub_to_zero",    64'h0000000000000001, 64'h3FE0000000000000, 64'h0000000000000000};
    vecs[7]  = '{"y_nan",          64'h3FF0000000000000, 64'h7FF0000000000001, 64'h7FF8000000000001};
    vecs[8]  = '{"nan_priority",   64'hFFF0000000000002, 64'h7FF8000000000000, 64'hFFF8000000000002};
    vecs[9]  = '{"zero_x_inf",     64'h8000000000000000, 64'h7FF0000000000000, 64'hFFF8000000000000};
    vecs[10] = '{"inf_x_neg",      64'h7FF0000000000000, 64'hC000000000000000, 64'hFFF0000000000000};
    vecs[11] = '{"zero_signed",    64'h0000000000000000, 64'hC000000000000000, 64'h8000000000000000};
    vecs[12] = '{"rne_down",       64'h3FF0000000000001, 64'h3FF0000000000001, 64'h3FF0000000000002};
    vecs[13] = '{"rne_tie_up",     64'h3FF0000000000001, 64'h3FF8000000000000, 64'h3FF8000000000002};
    vecs[14] = '{"round_min_norm", 64'h0010000000000000, 64'h3FEFFFFFFFFFFFFF, 64'h0010000000000000};
    vecs[15] = '{"tiny_x_tiny",    64'h8000000000000001, 64'h0000000000000001, 64'h8000000000000000};

    RESET       = 1'b1;
    bus.ENABLE  = 1'b0;
    bus.DATA_IN = 8'h00;
    repeat (3) nextCycle();
    checkVal("reset_ready", 64'(bus.READY), 64'd0);
    checkVal("reset_dout", 64'(bus.DATA_OUT), 64'd0);
    RESET = 1'b0;
    nextCycle();

    // Consecutive vectors run back to back: each load starts right after READY falls.
    for (int i = 0; i < 16; i++) begin
      applyStimulus(vecs[i].name, vecs[i].x, vecs[i].y, vecs[i].r, -1, 0);
      checkOutput();
    end

    applyStimulus("three_sq", 64'h4008000000000000, 64'h4008000000000000, 64'h4022000000000000, -1, 0);
    checkOutput();

    nextCycle();
    applyStimulus("enable_gap", 64'h3FF8000000000000, 64'h4000000000000000, 64'h4008000000000000, 5, 3);
    checkOutput();

    sendBytes({64'h7FF0000000000000, 64'h0000000000000000}, 11, -1, 0);
    RESET = 1'b1;
    nextCycle();
    RESET = 1'b0;
    checkVal("abort_ready", 64'(bus.READY), 64'd0);
    applyStimulus("after_abort", 64'h3FF8000000000000, 64'h4000000000000000, 64'h4008000000000000, -1, 0);
    checkOutput();

    $display("[TB] %0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
